// File: rtl/code_lock_if.sv
// Board-side bundle for code_lock_core: switch/button inputs from the master, status outputs from the slave.
interface code_lock_if #(
  parameter int WIDTH     = 8,
  parameter int SLOTS     = 4,
  parameter int MAX_TRIES = 3
);
  // Handshake: save_n/submit_n are raw active-low levels; each high-to-low transition is one request,
  // however long the button is held. Every output is a level that is valid in every cycle.
  logic                             mode;
  logic                             clr;
  logic [$clog2(SLOTS)-1:0]         slot_sel;
  logic [WIDTH-1:0]                 code_in;
  logic                             save_n;
  logic                             submit_n;
  logic                             unlocked;
  logic                             alarm;
  logic [$clog2(MAX_TRIES+1)-1:0]   tries_left;
  logic [SLOTS-1:0]                 valid_mask;
  logic [$clog2(SLOTS)-1:0]         match_slot;
  logic [1:0]                       state_dbg;

  modport master (
    output mode, clr, slot_sel, code_in, save_n, submit_n,
    input  unlocked, alarm, tries_left, valid_mask, match_slot, state_dbg
  );
  modport slave (
    input  mode, clr, slot_sel, code_in, save_n, submit_n,
    output unlocked, alarm, tries_left, valid_mask, match_slot, state_dbg
  );
endinterface

// File: rtl/code_lock_core.sv
// Multi-slot code lock: button conditioning, code storage, retry counting, timed unlock and lockout.
module code_lock_core #(
  parameter int WIDTH          = 8,
  parameter int SLOTS          = 4,
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 50_000_000,
  parameter int LOCKOUT_CYCLES = 500_000_000
) (
  input logic        clk,
  input logic        rst_n,
  code_lock_if.slave lk
);
  localparam int SW   = $clog2(SLOTS);
  localparam int FW   = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX);

  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] MAX_T     = FW'(MAX_TRIES);
  localparam logic [SW:0]   SLOTS_V   = (SW+1)'(SLOTS);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CHECK    = 2'd1;
  localparam logic [1:0] S_UNLOCKED = 2'd2;
  localparam logic [1:0] S_LOCKOUT  = 2'd3;

  logic [1:0]       state;
  logic [FW-1:0]    fail;
  logic [FW-1:0]    fail_inc;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] latched;
  logic [SW-1:0]    match;
  logic [SLOTS-1:0] valid;
  logic [WIDTH-1:0] codes [SLOTS];

  // [0],[1] synchronise the raw button, [2] remembers the previous synchronised level.
  logic [2:0] save_sr, submit_sr;
  logic       save_p, submit_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      save_sr   <= '1;
      submit_sr <= '1;
    end else begin
      save_sr   <= {save_sr[1:0], lk.save_n};
      submit_sr <= {submit_sr[1:0], lk.submit_n};
    end
  end

  assign save_p   = save_sr[2] & ~save_sr[1];
  assign submit_p = submit_sr[2] & ~submit_sr[1];

  logic slot_ok, save_ok;
  assign slot_ok = ({1'b0, lk.slot_sel} < SLOTS_V);
  // In IDLE only empty slots (or a completely empty lock) may be written; submit wins a collision.
  assign save_ok = save_p && !submit_p && lk.mode && slot_ok &&
                   ((state == S_IDLE && (!valid[lk.slot_sel] || valid == '0)) ||
                    state == S_UNLOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= '0;
    else if (save_ok) valid[lk.slot_sel] <= ~lk.clr;
  end

  always_ff @(posedge clk) begin
    if (save_ok && !lk.clr) codes[lk.slot_sel] <= lk.code_in;
  end

  logic          hit;
  logic [SW-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (valid[i] && codes[i] == latched) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign fail_inc = fail + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      fail    <= '0;
      timer   <= '0;
      latched <= '0;
      match   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (submit_p && !lk.mode && valid != '0) begin
            latched <= lk.code_in;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit) begin
            match <= hit_idx;
            fail  <= '0;
            timer <= OPEN_LOAD;
            state <= S_UNLOCKED;
          end else if (fail_inc == MAX_T) begin
            fail  <= MAX_T;
            timer <= LOCK_LOAD;
            state <= S_LOCKOUT;
          end else begin
            fail  <= fail_inc;
            state <= S_IDLE;
          end
        end
        S_UNLOCKED: begin
          if (submit_p && !lk.mode) state <= S_IDLE;
          else if (timer == '0)     state <= S_IDLE;
          else                      timer <= timer - 1'b1;
        end
        S_LOCKOUT: begin
          if (timer == '0) begin
            fail  <= '0;
            state <= S_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lk.unlocked   = (state == S_UNLOCKED);
  assign lk.alarm      = (state == S_LOCKOUT);
  assign lk.tries_left = MAX_T - fail;
  assign lk.valid_mask = valid;
  assign lk.match_slot = match;
  assign lk.state_dbg  = state;
endmodule
